axis_fifo: RTL and testbench
============================

Name: axis_fifo

Overview:
- Parametrised synchronous AXI-stream FIFO with first-word fall-through output and optional store-and-forward packet mode.
- Sits between any two stream producer/consumer pairs in the datapath, e.g. decoupling compute pipelines from memory readers.
- Generalises a bare stream link with buffering depth, occupancy reporting, and packet-gated release keyed on last.

Parameters:
- DATA_WIDTH, 32: width of s_data/m_data.
- DEPTH, 16: entries of storage; power of two, >= 2.
- PACKET_MODE, 0: 0 = word FIFO; 1 = output only when a complete packet (word with last) is stored.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  DATA_WIDTH  slave stream data.
- s_valid  input  1  slave stream valid.
- s_last  input  1  slave stream end-of-packet.
- s_ready  output  1  FIFO can accept a word.
- m_data  output  DATA_WIDTH  master stream data (head entry).
- m_valid  output  1  head entry presented.
- m_last  output  1  last flag of head entry.
- m_ready  input  1  downstream accepts.
- count  output  $clog2(DEPTH)+1  stored words.
- pkt_count  output  $clog2(DEPTH)+1  stored words with last=1 (complete packets).

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array holding {last, data}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0. The array is not reset.
- Reset (rst_n low, async): pointers, count and pkt_count go to 0. Outputs s_ready=0, m_valid=0, m_last=0. m_data is don't-care. Releasing reset mid-stream discards all contents.
- s_ready = rst_n_synced_ok && (count != DEPTH). It is registered-state-derived only and never depends on m_ready; full-with-simultaneous-pop does not accept. s_ready goes to 1 on the first clk edge after reset deassert.
- push = s_valid && s_ready; the word is written at wr_ptr and wr_ptr increments.
- pop = m_valid && m_ready; rd_ptr increments.
- count is updated each cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- pkt_count is updated each cycle: +1 if push with s_last; -1 if pop with m_last; both -> unchanged.
- m_data and m_last are combinational reads of mem[rd_ptr] (FWFT).
- PACKET_MODE=0: m_valid = (count != 0). A word pushed at edge N is visible with m_valid=1 after edge N (latency 1 cycle, no bypass).
- PACKET_MODE=1: m_valid = (count != 0) && (pkt_count != 0 || count == DEPTH).
  - The full-fallback releases words of a packet longer than DEPTH in cut-through fashion to prevent deadlock.
  - Release continues while the FIFO stays full.
  - If a pop drops count below DEPTH and no last is stored, m_valid deasserts until refilled or last arrives.
- AXI rules:
  - m_valid/m_data/m_last stay stable while m_valid && !m_ready, because no pop occurs and the head is unchanged.
  - A push never alters the head entry when count != 0.
  - The upstream drives s_valid independently of s_ready.
- Empty plus simultaneous push: there is no pop that cycle; the word appears next cycle.
- Full plus pop: s_ready=0 that cycle; s_ready=1 the next cycle.
- Invariants: count <= DEPTH and pkt_count <= count always. Assertions cover: no push when full, no pop when empty, and held data stable under backpressure.

Test Plan:
- Reset then idle, PACKET_MODE=0 -> s_ready=1 one cycle after rst_n rises; m_valid=0, count=0.
- DEPTH=16, PACKET_MODE=0: push 0x0..0xF back-to-back with m_ready=0 -> count=16, s_ready=0. The 17th word is not accepted. Then m_ready=1 -> 0x0..0xF out in order, count returns to 0.
- Continuous stream with s_valid and m_ready both randomly toggled, 10000 words -> output sequence equals input sequence. count never exceeds 16. m_data stays stable whenever m_valid && !m_ready.
- PACKET_MODE=1: push 0xA1, 0xA2, 0xA3 (last on 0xA3), one per cycle -> m_valid=0 until the cycle after 0xA3 is pushed. pkt_count then goes 0->1. The packet drains with m_last=1 only on 0xA3, and pkt_count returns to 0.
- PACKET_MODE=1, DEPTH=4: 6-word packet without early last -> m_valid asserts when count=4. Words 1..6 are delivered in order, m_last=1 on word 6, and there is no deadlock.
- Assert rst_n low mid-transfer with count=7 -> immediately count=0, pkt_count=0, m_valid=0, s_ready=0. After release, the first new word pushed is the first word out.

Source files
------------

// File: rtl/axis_fifo.sv
// ============================================================================
// axis_fifo : AXI-stream FIFO, first-word fall-through, optional packet mode
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axis_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_pkt_count;
  logic                r_ready_en;
  logic                w_push;
  logic                w_pop;
  logic                w_m_valid;
  logic [DATA_WIDTH:0] w_head;

  // Holds s_ready low until the first edge after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  assign s_ready = r_ready_en && (r_count != C_FULL);
  assign w_push  = s_valid && s_ready;
  assign w_pop   = w_m_valid && m_ready;
  assign w_head  = r_mem[r_rd_ptr];

  generate
    if (PACKET_MODE != 0) begin : g_packet
      // Full fallback releases oversize packets so the FIFO cannot deadlock
      assign w_m_valid = (r_count != '0) && ((r_pkt_count != '0) || (r_count == C_FULL));
    end else begin : g_word
      assign w_m_valid = (r_count != '0);
    end
  endgenerate

  assign m_valid   = w_m_valid;
  assign m_data    = w_head[DATA_WIDTH-1:0];
  assign m_last    = w_m_valid && w_head[DATA_WIDTH];
  assign count     = r_count;
  assign pkt_count = r_pkt_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_push && s_last, w_pop && m_last})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (r_count != C_FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    w_pop |-> (r_count != '0));
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));
  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (r_count <= C_FULL) && (r_pkt_count <= r_count));
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo.sv
// ============================================================================
// tb_axis_fifo : scoreboard bench for a word-mode and a packet-mode FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mon_en;

  logic [31:0] s_data0, m_data0, s_data1, m_data1;
  logic        s_valid0, s_last0, s_ready0, m_valid0, m_last0, m_ready0;
  logic        s_valid1, s_last1, s_ready1, m_valid1, m_last1, m_ready1;
  logic [4:0]  count0, pkt0;
  logic [2:0]  count1, pkt1;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sbq0 [$];
  logic [32:0] sbq1 [$];
  bit          held [2];
  logic [31:0] held_data [2];
  int          rcvd [2];
  int          base, sent, guard;
  bit          acc;

  always #5 clk = ~clk;

  axis_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) u_word (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data0), .s_valid(s_valid0), .s_last(s_last0), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready0),
    .count(count0), .pkt_count(pkt0)
  );

  axis_fifo #(.DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data1), .s_valid(s_valid1), .s_last(s_last1), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready1),
    .count(count1), .pkt_count(pkt1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of one FIFO: occupancy, packet count, flags and head word
  task automatic monitor(input int i, input int depth, input bit pm,
                         input logic srdy, input logic sval, input logic sl, input logic [31:0] sd,
                         input logic mval, input logic ml, input logic [31:0] md, input logic mrdy,
                         input int cnt, input int pkt);
    logic [32:0] q [$];
    int sz, npkt;
    bit exp_valid;
    if (i == 0) q = sbq0; else q = sbq1;
    sz   = q.size();
    npkt = 0;
    for (int k = 0; k < sz; k++) if (q[k][32]) npkt++;
    exp_valid = pm ? ((sz != 0) && ((npkt != 0) || (sz == depth))) : (sz != 0);
    check_eq($sformatf("u%0d.count", i), cnt, sz);
    check_eq($sformatf("u%0d.pkt_count", i), pkt, npkt);
    check_eq($sformatf("u%0d.s_ready", i), srdy, sz != depth);
    check_eq($sformatf("u%0d.m_valid", i), mval, exp_valid);
    if (held[i]) check_eq($sformatf("u%0d.hold", i), {mval, md}, {1'b1, held_data[i]});
    if (mval && sz != 0) check_eq($sformatf("u%0d.head", i), {ml, md}, q[0]);
    held[i]      = mval && !mrdy;
    held_data[i] = md;
    if (mval && mrdy && sz != 0) begin
      void'(q.pop_front());
      rcvd[i]++;
    end
    if (sval && srdy) q.push_back({sl, sd});
    if (i == 0) sbq0 = q; else sbq1 = q;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq0.delete();
      sbq1.delete();
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else if (mon_en) begin
      monitor(0, 16, 1'b0, s_ready0, s_valid0, s_last0, s_data0,
              m_valid0, m_last0, m_data0, m_ready0, int'(count0), int'(pkt0));
      monitor(1, 4, 1'b1, s_ready1, s_valid1, s_last1, s_data1,
              m_valid1, m_last1, m_data1, m_ready1, int'(count1), int'(pkt1));
    end
  end

  task automatic push0(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    s_valid0 = 1'b1; s_data0 = d; s_last0 = l;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = s_ready0;
      @(posedge clk); #1;
    end
    s_valid0 = 1'b0;
    if (!ok) check_eq("push0_timeout", 1, 0);
  endtask

  task automatic push1(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    s_valid1 = 1'b1; s_data1 = d; s_last1 = l;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = s_ready1;
      @(posedge clk); #1;
    end
    s_valid1 = 1'b0;
    if (!ok) check_eq("push1_timeout", 1, 0);
  endtask

  task automatic drain(input int i);
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (i == 0) ? (count0 == 5'd0) : (count1 == 3'd0);
    end
    check_eq($sformatf("drain%0d", i), done, 1);
  endtask

  initial begin
    rst_n = 1'b0; mon_en = 1'b0;
    s_valid0 = 1'b0; s_data0 = '0; s_last0 = 1'b0; m_ready0 = 1'b0;
    s_valid1 = 1'b0; s_data1 = '0; s_last1 = 1'b0; m_ready1 = 1'b0;
    rcvd[0] = 0; rcvd[1] = 0;

    // Reset state and s_ready release timing
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", s_ready0, 0);
    check_eq("rst_m_valid", m_valid0, 0);
    check_eq("rst_m_last", m_last0, 0);
    check_eq("rst_count", count0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_before_edge", s_ready0, 0);
    @(posedge clk); #1 mon_en = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_edge", s_ready0, 1);
    check_eq("idle_m_valid", m_valid0, 0);

    // Fill the word FIFO, refuse a 17th word, then drain in order
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) push0(32'(k), 1'b0);
    s_valid0 = 1'b1; s_data0 = 32'h10; s_last0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("full_count", count0, 16);
      check_eq("full_s_ready", s_ready0, 0);
    end
    @(posedge clk); #1 s_valid0 = 1'b0; m_ready0 = 1'b1;
    drain(0);
    check_eq("fill_rcvd", rcvd[0], 16);

    // Random stream with independent valid/ready toggling
    @(posedge clk); #1 m_ready0 = 1'b0;
    base = rcvd[0]; sent = 0; guard = 0;
    while (rcvd[0] < base + 10000 && guard < 60000) begin
      @(negedge clk); acc = s_valid0 && s_ready0;
      @(posedge clk); #1; guard++;
      if (acc) sent++;
      if (!s_valid0 || acc) begin
        s_valid0 = (sent < 10000) && ($urandom_range(0, 3) != 0);
        s_data0  = $urandom;
        s_last0  = ($urandom_range(0, 3) == 0);
      end
      m_ready0 = ($urandom_range(0, 3) != 0);
    end
    s_valid0 = 1'b0; m_ready0 = 1'b0;
    check_eq("stream_words", rcvd[0] - base, 10000);

    // Packet mode: output gated until the last word is stored
    m_ready1 = 1'b1;
    push1(32'hA1, 1'b0);
    push1(32'hA2, 1'b0);
    @(negedge clk);
    check_eq("pkt_gated", m_valid1, 0);
    @(posedge clk); #1;
    push1(32'hA3, 1'b1);
    @(negedge clk);
    check_eq("pkt_count_up", pkt1, 1);
    check_eq("pkt_released", m_valid1, 1);
    check_eq("pkt_head", m_data1, 32'hA1);
    drain(1);
    check_eq("pkt_count_down", pkt1, 0);

    // Oversize packet released through the full fallback
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) push1(32'(k), 1'b0);
    @(negedge clk);
    check_eq("cut_count", count1, 4);
    check_eq("cut_valid", m_valid1, 1);
    @(posedge clk); #1;
    push1(32'd5, 1'b0);
    push1(32'd6, 1'b1);
    drain(1);
    check_eq("cut_rcvd", rcvd[1], 9);

    // Asynchronous reset in the middle of a transfer
    @(posedge clk); #1 m_ready0 = 1'b0;
    for (int k = 0; k < 7; k++) push0(32'h100 + 32'(k), 1'(k == 3));
    @(negedge clk);
    check_eq("pre_rst_count", count0, 7);
    @(posedge clk); #2 rst_n = 1'b0; mon_en = 1'b0;
    #1;
    check_eq("mid_rst_count", count0, 0);
    check_eq("mid_rst_pkt", pkt0, 0);
    check_eq("mid_rst_m_valid", m_valid0, 0);
    check_eq("mid_rst_s_ready", s_ready0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    push0(32'h55, 1'b1);
    push0(32'h66, 1'b0);
    @(negedge clk);
    check_eq("post_rst_first", {m_valid0, m_data0}, {1'b1, 32'h55});
    @(posedge clk); #1 m_ready0 = 1'b1;
    drain(0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
